mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10: memory address width; requester address bits above ADDR_W-1 are ignored.
REQ-002 Parameter RD_LAT, default 2: cycles mem_rden is held before mem_rdata is sampled (range 1..7).
REQ-003 Clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 c_req  in  1  CPU request; held high until c_ack.
REQ-006 c_we  in  1  CPU access type; 1 = write, 0 = read.
REQ-007 c_addr  in  16  CPU word address.
REQ-008 c_wdata  in  16  CPU write data.
REQ-009 c_rdata  out  16  CPU read data; valid in the c_ack cycle and held until that port's next read completes.
REQ-010 c_ack  out  1  one-cycle CPU completion pulse.
REQ-011 d_req, d_we, d_addr[16], d_wdata[16], d_rdata[16], d_ack: debug/loader port; same widths and semantics as REQ-005..REQ-010.
REQ-012 mem_addr  out  ADDR_W  memory address.
REQ-013 mem_wdata  out  16  memory write data.
REQ-014 mem_rden  out  1  memory read enable.
REQ-015 mem_wren  out  1  memory write enable.
REQ-016 mem_rdata  in  16  memory read data.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 grant  out  1  port owning the current transaction; 0 = CPU, 1 = debug.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, RD, WR, ACK.
REQ-020 In IDLE with exactly one req high, that port SHALL be granted; with no req high, the FSM SHALL stay in IDLE.
REQ-021 In IDLE with both reqs high, the port not granted last SHALL win (round-robin); last-grant SHALL update on every grant.
REQ-022 At grant, the winning port's addr, we and wdata SHALL be latched; later changes on that port SHALL be ignored until its ack.
REQ-023 The FSM SHALL go IDLE->WR when latched we=1 and IDLE->RD when latched we=0.
REQ-024 In WR, mem_wren SHALL be high for exactly one cycle with latched mem_addr and mem_wdata; the FSM SHALL then go to ACK.
REQ-025 In RD, mem_rden SHALL be high for RD_LAT consecutive cycles; mem_rdata SHALL be captured into the granted port's rdata register on the last of these cycles; the FSM SHALL then go to ACK.
REQ-026 In ACK, only the granted port's ack SHALL be high, for one cycle; the FSM SHALL then return to IDLE.
REQ-027 Latency, request sampled in IDLE at cycle 0: a write SHALL have mem_wren at cycle 1 and ack at cycle 2; a read SHALL have mem_rden in cycles 1..RD_LAT and ack at cycle RD_LAT+1.
REQ-028 A req still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-029 mem_rden and mem_wren SHALL never be high in the same cycle.
REQ-030 Every output SHALL be driven from a register, with no combinational path from any input.
REQ-031 Outside RD and WR, mem_rden and mem_wren SHALL be 0 and mem_addr/mem_wdata SHALL hold their last values.
REQ-032 Addresses SHALL alias modulo 2^ADDR_W.

Reset
REQ-033 Reset SHALL force state IDLE, all outputs to 0, both rdata registers to 0, and last-grant to 1, so the CPU wins the first tie.
REQ-034 Reset during RD, WR or ACK SHALL abort the transaction with no ack issued and mem_wren low in the following cycle.

Structure
REQ-035 The shared package slc3_mem_pkg SHALL hold the state enum, the PORT_CPU=0 and PORT_DBG=1 constants, and the ADDR_W default.
REQ-036 The round-robin pick and last-grant register SHALL be a sub-module, rr_arb2; the FSM, latency counter and latches SHALL live in mem_arbiter.

Verification
REQ-037 Scenario: CPU write addr 0x0012, data 0xBEEF -> mem_wren at cycle 1 with mem_addr 0x012, c_ack at cycle 2.
REQ-038 Scenario: CPU read of 0x0012 with RD_LAT=2 -> mem_rden in cycles 1-2, c_ack at cycle 3, c_rdata=0xBEEF.
REQ-039 Scenario: both ports request reads of 0x005 in the same cycle after reset -> CPU served first, then debug; d_ack follows c_ack with one IDLE cycle between.
REQ-040 Scenario: both reqs held high continuously -> grant alternates 0,1,0,1 across four transactions.
REQ-041 Scenario: Reset asserted during the second RD cycle -> no ack, all outputs 0 next cycle, next tie goes to the CPU.
REQ-042 Scenario: debug write to 0x0412 with ADDR_W=10 -> mem_addr=0x012; a CPU read of 0x0012 returns that data.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package slc3_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REQ_ADDR_W = 16;
  localparam int unsigned CNT_W      = 3;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RD   = 2'd1;
  localparam state_t ST_WR   = 2'd2;
  localparam state_t ST_ACK  = 2'd3;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick with a last-grant register; the port not granted last wins a tie.
module rr_arb2
  import slc3_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       pick_c
);

  logic last;

  // req[0] is the CPU, req[1] the debug port
  always_comb begin
    pick_c = PORT_CPU;
    if (req[1] && (!req[0] || (last == PORT_CPU))) pick_c = PORT_DBG;
  end

  // Reset to the debug port so the CPU wins the first tie
  always_ff @(posedge clk) begin
    if (reset)     last <= PORT_DBG;
    else if (take) last <= pick_c;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and debug ports onto one single-ported memory; one transaction at a time.
module mem_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [REQ_ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0]     c_wdata,
  output logic [DATA_W-1:0]     c_rdata,
  output logic                  c_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [REQ_ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_ack,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic                  grant
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, c_rdata_nxt, d_rdata_nxt;
  logic              mem_rden_nxt, mem_wren_nxt, c_ack_nxt, d_ack_nxt, busy_nxt, grant_nxt;
  logic              take_c, pick_c;
  req_t              sel;
  logic              unused_addr_hi;

  assign take_c = (state == ST_IDLE) && (c_req || d_req);

  rr_arb2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    ({d_req, c_req}),
    .take   (take_c),
    .pick_c (pick_c)
  );

  // Address bits above ADDR_W alias away
  assign unused_addr_hi = ^sel.addr;

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_rden_nxt  = mem_rden;
    mem_wren_nxt  = 1'b0;
    c_ack_nxt     = 1'b0;
    d_ack_nxt     = 1'b0;
    c_rdata_nxt   = c_rdata;
    d_rdata_nxt   = d_rdata;
    grant_nxt     = grant;
    sel           = (pick_c == PORT_DBG) ? req_t'{d_we, d_addr, d_wdata}
                                         : req_t'{c_we, c_addr, c_wdata};
    case (state)
      ST_IDLE: begin
        if (take_c) begin
          grant_nxt     = pick_c;
          mem_addr_nxt  = sel.addr[ADDR_W-1:0];
          mem_wdata_nxt = sel.wdata;
          cnt_nxt       = '0;
          if (sel.we) begin
            state_nxt    = ST_WR;
            mem_wren_nxt = 1'b1;
          end else begin
            state_nxt    = ST_RD;
            mem_rden_nxt = 1'b1;
          end
        end
      end
      ST_WR: begin
        state_nxt = ST_ACK;
        c_ack_nxt = (grant == PORT_CPU);
        d_ack_nxt = (grant == PORT_DBG);
      end
      ST_RD: begin
        if (cnt == CNT_W'(RD_LAT - 1)) begin
          state_nxt    = ST_ACK;
          mem_rden_nxt = 1'b0;
          c_ack_nxt    = (grant == PORT_CPU);
          d_ack_nxt    = (grant == PORT_DBG);
          if (grant == PORT_CPU) c_rdata_nxt = mem_rdata;
          else                   d_rdata_nxt = mem_rdata;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rden  <= 1'b0;
      mem_wren  <= 1'b0;
      c_ack     <= 1'b0;
      d_ack     <= 1'b0;
      c_rdata   <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
      grant     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_rden  <= mem_rden_nxt;
      mem_wren  <= mem_wren_nxt;
      c_ack     <= c_ack_nxt;
      d_ack     <= d_ack_nxt;
      c_rdata   <= c_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      busy      <= busy_nxt;
      grant     <= grant_nxt;
    end
  end

endmodule
